sbox_sched: RTL

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/sbox_sched.sv | 114 +++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
// Schedules one 64-bit S-layer through a shared dual-port 8-bit S-box ROM: two bytes per slot,
// four issue slots, one drain cycle for the registered ROM, then holds the result until accepted.
module sbox_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic [7:0]  rom_addra,
   output logic [7:0]  rom_addrb,
   input  logic [7:0]  rom_douta,
   input  logic [7:0]  rom_doutb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic [63:0] word;
   logic [47:0] res;

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   function automatic logic [7:0] rotr1(input logic [7:0] v);
      return {v[0], v[7:1]};
   endfunction

   // ROM address pair for slot k: bytes 2k+1 (port A) and 2k+2 (port B); x4, x7 are s4 inputs.
   function automatic logic [15:0] addr_pair(input logic [63:0] w, input logic [1:0] k);
      case (k)
         2'd0:    return {w[63:56], w[55:48]};
         2'd1:    return {w[47:40], rotl1(w[39:32])};
         2'd2:    return {w[31:24], w[23:16]};
         default: return {rotl1(w[15:8]), w[7:0]};
      endcase
   endfunction

   // Output mapping for the pair returned from slot k: y2, y5 are s2 and y3, y6 are s3.
   function automatic logic [15:0] out_pair(input logic [1:0] k, input logic [7:0] a,
                                            input logic [7:0] b);
      case (k)
         2'd0:    return {a, rotl1(b)};
         2'd1:    return {rotr1(a), b};
         2'd2:    return {rotl1(a), rotr1(b)};
         default: return {a, b};
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         word      <= 64'd0;
         res       <= 48'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= 64'd0;
         busy      <= 1'b0;
         rom_addra <= 8'h00;
         rom_addrb <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  word                   <= in_data;
                  cnt                    <= 2'd0;
                  {rom_addra, rom_addrb} <= addr_pair(in_data, 2'd0);
                  in_ready               <= 1'b0;
                  busy                   <= 1'b1;
                  state                  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= cnt + 2'd1;
               // Data on the ROM ports belongs to the previous slot.
               case (cnt)
                  2'd1:    res[47:32] <= out_pair(2'd0, rom_douta, rom_doutb);
                  2'd2:    res[31:16] <= out_pair(2'd1, rom_douta, rom_doutb);
                  2'd3:    res[15:0]  <= out_pair(2'd2, rom_douta, rom_doutb);
                  default: ;
               endcase
               if (cnt == 2'd3) begin
                  rom_addra <= 8'h00;
                  rom_addrb <= 8'h00;
                  state     <= DRAIN;
               end else begin
                  {rom_addra, rom_addrb} <= addr_pair(word, cnt + 2'd1);
               end
            end
            DRAIN: begin
               out_data  <= {res, out_pair(2'd3, rom_douta, rom_doutb)};
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
